// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI master transmitter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  // Half-period counter width; a divider of 1 would still need one bit.
  function automatic int div_cnt_w(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_master_tx_rise_detect.sv
// Single-register rising-edge detector; the history register resets high so a
// level already asserted when reset releases is not treated as an event.
module rise_detect (
  input  logic clk_100,
  input  logic a_rst,
  input  logic s_rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      prev_q <= 1'b1;
    end else if (s_rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: a wrapping counter advanced by next_count events is
// latched and shifted out MSB-first as one frame on each start_send event.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_100,
  input  logic              a_rst,
  input  logic              s_rst,
  input  logic              next_count,
  input  logic              start_send,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] count_o,
  output spi_state_t        state_o
);

  localparam int DIV_CNT_W = div_cnt_w(CLK_DIV);
  localparam int BIT_CNT_W = bit_cnt_w(DATA_W);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);

  logic count_rise;
  logic send_rise;

  rise_detect u_count_rise (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .s_rst   (s_rst),
    .sig_i   (next_count),
    .rise_o  (count_rise)
  );

  rise_detect u_send_rise (
    .clk_100 (clk_100),
    .a_rst   (a_rst),
    .s_rst   (s_rst),
    .sig_i   (start_send),
    .rise_o  (send_rise)
  );

  logic [DATA_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (count_rise) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      count_q <= '0;
    end else if (s_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  spi_state_t           state_q;
  logic [DIV_CNT_W-1:0] div_q;
  logic [BIT_CNT_W-1:0] bit_q;
  logic [DATA_W-1:0]    shreg_q;
  logic                 sclk_q, mosi_q, cs_n_q, busy_q, done_q;
  logic                 div_last;

  assign div_last = (div_q == DIV_LAST);

  // A bit period is the high half then the low half of SCLK; the frame
  // leaves SHIFT only after the low half of the final bit.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (s_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The done cycle is skipped so cs_n stays high for at least two cycles.
          if (send_rise && !done_q) begin
            state_q <= LEAD;
            shreg_q <= count_q;
            mosi_q  <= count_q[DATA_W-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
          end
        end
        LEAD: begin
          if (div_last) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              if (bit_q != BIT_LAST) begin
                mosi_q  <= shreg_q[DATA_W-2];
                shreg_q <= shreg_q << 1;
              end
            end else if (bit_q == BIT_LAST) begin
              state_q <= TRAIL;
            end else begin
              sclk_q <= 1'b1;
              bit_q  <= bit_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        TRAIL: begin
          if (div_last) begin
            state_q <= IDLE;
            div_q   <= '0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count_o = count_q;
  assign state_o = state_q;

endmodule
